snake_body_engine: RTL
======================

// Module: snake_body_engine
// PURPOSE
//  Game-state producer for the snake playfield. On each game tick it advances the head one cell,
//  shifts the body, grows on apple, detects wall/self collision. Publishes head, length and packed
//  body buses that the per-frame snapshot register samples at frame_start for the pixel renderer.
//  Sits between input/tick logic and the frame snapshot stage, on clk_pix.
// PARAMETERS
//  MAX_LEN  33   max segments incl. head; bus widths MAX_LEN*10 / MAX_LEN*9
//  CELL     16   pixel step per move
//  H_RES    640  playfield width (px); legal x = 0..H_RES-CELL
//  V_RES    480  playfield height (px); legal y = 0..V_RES-CELL
//  INIT_LEN 3    length after reset/restart (2..MAX_LEN)
//  START_X  320  initial head x; START_Y 240 initial head y
// PORTS
//  clk_pix     in  1   pixel clock, single clock domain
//  rst_n       in  1   asynchronous active-low reset
//  tick        in  1   1-cycle game step request
//  restart     in  1   synchronous re-init (same values as reset)
//  dir         in  2   requested direction: 00 up, 01 right, 10 down, 11 left
//  apple_x     in  10  apple cell x;  apple_y in 9 apple cell y
//  head_x      out 10  current head x (== body segment 0 x)
//  head_y      out 9   current head y
//  snake_len   out 8   live segment count, INIT_LEN..MAX_LEN
//  body_bus_x  out MAX_LEN*10  segment i x at [i*10 +: 10], i=0 head
//  body_bus_y  out MAX_LEN*9   segment i y at [i*9 +: 9]
//  ate         out 1   1-cycle pulse: head landed on apple this step
//  step_done   out 1   1-cycle pulse: step (move + check) finished
//  busy        out 1   high from MOVE through CHECK
//  game_over   out 1   sticky until restart/reset
// BEHAVIOUR
//  Reset/restart: seg i = (START_X - i*CELL, START_Y) for i<INIT_LEN, others 0; snake_len=INIT_LEN;
//   cur_dir=right; ate, step_done, busy, game_over = 0; state IDLE. restart wins over tick.
//  FSM IDLE -> MOVE -> CHECK -> IDLE.
//  IDLE: tick && !game_over -> MOVE; latch dir into cur_dir unless it is the 180° reverse (ignored).
//   tick while busy or game_over: dropped, no queueing.
//  MOVE (1 cycle): nx/ny = head +/- CELL per cur_dir.
//   Out of range (x=0 going left, x>H_RES-CELL, y=0 going up, y>V_RES-CELL): game_over=1,
//    no shift, step_done pulses, -> IDLE.
//   Else: seg[i] <= seg[i-1] for i=1..MAX_LEN-1, seg[0] <= (nx,ny).
//    If (nx,ny)==(apple_x,apple_y): ate pulses; snake_len+1, saturates at MAX_LEN (ate still pulses).
//   -> CHECK, idx=1.
//  CHECK: one segment per cycle; if seg[idx]==seg[0] -> game_over=1. Ends after idx=snake_len-1
//   (first hit ends scan early); step_done pulses on exit, -> IDLE.
//   Latency tick->step_done = snake_len+1 cycles (no hit); 2 cycles on wall hit.
//  Segments >= snake_len hold stale shifted values; consumers must mask by snake_len.
//  Cell vacated by tail on a non-growing step is legal for the head (old tail beyond snake_len).
//  Outputs update only at MOVE edge; stable during CHECK and IDLE (safe for frame_start sampling).
//  Arithmetic: x in 10 bits, y in 9 bits; range check before store, no silent overflow.
// CONFIGURATION
//  SNAKE_WRAP_EN defined: walls wrap -- left of 0 -> H_RES-CELL, right past -> 0, same for y;
//   wall never sets game_over. Undefined: wall hit -> game_over as above.
// TESTING
//  1 reset, tick, dir=01 -> head (336,240), seg1 (320,240), seg2 (304,240), len 3, step_done @ +4.
//  2 apple (336,240), tick dir=01 -> ate 1 cycle, len 4, seg3 = (288,240).
//  3 head (0,240) dir=11, tick -> game_over, head unchanged; further ticks ignored;
//    SNAKE_WRAP_EN: head (624,240), game_over 0.
//  4 len 5, moves up/left/down in a square -> head hits seg3 in CHECK -> game_over, step_done.
//  5 moving right, dir=11 -> reversal ignored, head x +16; tick during busy -> no extra step.
//  6 len MAX_LEN, eat apple -> ate pulses, len stays 33; restart mid-CHECK -> reset values next cycle.

Source files
------------

// File: rtl/snake_body_engine.sv
// Snake game-state engine: per tick moves the head one cell, shifts the body, grows on apple, detects wall/self hits.
// Define SNAKE_WRAP_EN to wrap the head around the playfield edges instead of ending the game on a wall.
module snake_body_engine #(
  parameter int MAX_LEN  = 33,
  parameter int CELL     = 16,
  parameter int H_RES    = 640,
  parameter int V_RES    = 480,
  parameter int INIT_LEN = 3,
  parameter int START_X  = 320,
  parameter int START_Y  = 240
) (
  input  logic                  clk_pix,
  input  logic                  rst_n,
  input  logic                  tick,
  input  logic                  restart,
  input  logic [1:0]            dir,
  input  logic [9:0]            apple_x,
  input  logic [8:0]            apple_y,
  output logic [9:0]            head_x,
  output logic [8:0]            head_y,
  output logic [7:0]            snake_len,
  output logic [MAX_LEN*10-1:0] body_bus_x,
  output logic [MAX_LEN*9-1:0]  body_bus_y,
  output logic                  ate,
  output logic                  step_done,
  output logic                  busy,
  output logic                  game_over
);
  localparam int IW = $clog2(MAX_LEN);
  localparam logic [1:0] DIR_UP = 2'd0, DIR_RIGHT = 2'd1, DIR_DOWN = 2'd2, DIR_LEFT = 2'd3;

  // state | meaning
  // IDLE  | waiting for a tick
  // MOVE  | wall check, body shift, apple check (single cycle)
  // CHECK | compare one body segment per cycle against the new head
  typedef enum logic [1:0] {S_IDLE, S_MOVE, S_CHECK} state_t;

  state_t        state_q;
  logic [9:0]    seg_x_q [MAX_LEN];
  logic [8:0]    seg_y_q [MAX_LEN];
  logic [7:0]    len_q;
  logic [1:0]    dir_q;
  logic [IW-1:0] idx_q;
  logic          ate_q, done_q, busy_q, over_q;

  logic [9:0] nx_d;
  logic [8:0] ny_d;
  logic       wall_d, wall_hit, apple_hit, self_hit, scan_end;

  function automatic logic [9:0] init_x(input int i);
    return (i < INIT_LEN) ? 10'(START_X - i * CELL) : 10'd0;
  endfunction

  function automatic logic [8:0] init_y(input int i);
    return (i < INIT_LEN) ? 9'(START_Y) : 9'd0;
  endfunction

  // Range check happens on widened sums so an edge move can never silently overflow.
  always_comb begin
    nx_d   = seg_x_q[0];
    ny_d   = seg_y_q[0];
    wall_d = 1'b0;
    case (dir_q)
      DIR_UP:
        if (seg_y_q[0] < 9'(CELL)) begin
          wall_d = 1'b1;
          ny_d   = 9'(V_RES - CELL);
        end else ny_d = seg_y_q[0] - 9'(CELL);
      DIR_RIGHT:
        if ({1'b0, seg_x_q[0]} + 11'(CELL) > 11'(H_RES - CELL)) begin
          wall_d = 1'b1;
          nx_d   = '0;
        end else nx_d = seg_x_q[0] + 10'(CELL);
      DIR_DOWN:
        if ({1'b0, seg_y_q[0]} + 10'(CELL) > 10'(V_RES - CELL)) begin
          wall_d = 1'b1;
          ny_d   = '0;
        end else ny_d = seg_y_q[0] + 9'(CELL);
      default:
        if (seg_x_q[0] < 10'(CELL)) begin
          wall_d = 1'b1;
          nx_d   = 10'(H_RES - CELL);
        end else nx_d = seg_x_q[0] - 10'(CELL);
    endcase
  end

`ifdef SNAKE_WRAP_EN
  assign wall_hit = 1'b0;
`else
  assign wall_hit = wall_d;
`endif

  assign apple_hit = (nx_d == apple_x) && (ny_d == apple_y);
  assign self_hit  = (seg_x_q[idx_q] == seg_x_q[0]) && (seg_y_q[idx_q] == seg_y_q[0]);
  assign scan_end  = (8'(idx_q) == len_q - 8'd1);

  always_ff @(posedge clk_pix or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      len_q   <= 8'(INIT_LEN);
      dir_q   <= DIR_RIGHT;
      idx_q   <= '0;
      ate_q   <= 1'b0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
      over_q  <= 1'b0;
      for (int i = 0; i < MAX_LEN; i++) begin
        seg_x_q[i] <= init_x(i);
        seg_y_q[i] <= init_y(i);
      end
    end else if (restart) begin
      state_q <= S_IDLE;
      len_q   <= 8'(INIT_LEN);
      dir_q   <= DIR_RIGHT;
      idx_q   <= '0;
      ate_q   <= 1'b0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
      over_q  <= 1'b0;
      for (int i = 0; i < MAX_LEN; i++) begin
        seg_x_q[i] <= init_x(i);
        seg_y_q[i] <= init_y(i);
      end
    end else begin
      ate_q  <= 1'b0;
      done_q <= 1'b0;
      case (state_q)
        S_IDLE:
          if (tick && !over_q) begin
            if (dir != (dir_q ^ 2'b10)) dir_q <= dir;
            busy_q  <= 1'b1;
            state_q <= S_MOVE;
          end
        S_MOVE:
          if (wall_hit) begin
            over_q  <= 1'b1;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end else begin
            for (int i = 1; i < MAX_LEN; i++) begin
              seg_x_q[i] <= seg_x_q[i-1];
              seg_y_q[i] <= seg_y_q[i-1];
            end
            seg_x_q[0] <= nx_d;
            seg_y_q[0] <= ny_d;
            if (apple_hit) begin
              ate_q <= 1'b1;
              if (len_q != 8'(MAX_LEN)) len_q <= len_q + 8'd1;
            end
            idx_q   <= IW'(1);
            state_q <= S_CHECK;
          end
        S_CHECK:
          if (self_hit || scan_end) begin
            if (self_hit) over_q <= 1'b1;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end else idx_q <= idx_q + IW'(1);
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign head_x    = seg_x_q[0];
  assign head_y    = seg_y_q[0];
  assign snake_len = len_q;
  assign ate       = ate_q;
  assign step_done = done_q;
  assign busy      = busy_q;
  assign game_over = over_q;

  for (genvar g = 0; g < MAX_LEN; g++) begin : g_bus
    assign body_bus_x[g*10 +: 10] = seg_x_q[g];
    assign body_bus_y[g*9 +: 9]   = seg_y_q[g];
  end
endmodule
